// File: rtl/rsa_message_sequencer_pkg.sv
// Shared widths, default parameters and state encoding for the RSA message sequencer.
package rsa_message_sequencer_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_TIMEOUT    = 1023;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rsa_byte_fifo.sv
// Plaintext byte FIFO: refuses pushes when full, never bypasses when empty.
module rsa_byte_fifo
  import rsa_message_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rsa_message_sequencer.sv
// Feeds buffered plaintext bytes one at a time to an RSA encryptor and streams
// the resulting ciphertext words downstream.
module rsa_message_sequencer
  import rsa_message_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] enc_data,
  output logic              enc_start,
  input  logic              enc_done,
  input  logic [WORD_W-1:0] enc_result,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  msg_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  seq_state_e        r_state;
  logic [TW-1:0]     r_wait_cnt;
  logic [BYTE_W-1:0] r_enc_data;
  logic              r_enc_start;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_msg_count;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head;

  assign w_pop    = (r_state == ST_IDLE) && !w_empty;
  assign in_ready = !w_full;

  rsa_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer FSM; the first WAIT cycle ignores enc_done because it may still
  // carry the previous message's completion level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_enc_data    <= '0;
      r_enc_start   <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_msg_count   <= '0;
    end else begin
      r_enc_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_enc_data  <= w_head;
            r_enc_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if ((r_wait_cnt != '0) && enc_done) begin
            r_out_data  <= enc_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_msg_count <= r_msg_count + CNT_W'(1);
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign enc_data    = r_enc_data;
  assign enc_start   = r_enc_start;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign msg_count   = r_msg_count;

endmodule

// File: tb/tb_rsa_message_sequencer.sv
// Randomized bench for rsa_message_sequencer: a timestamp/queue model of the
// sequencing rules is checked against every DUT output on every cycle.
module tb_rsa_message_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 1023;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  enc_data;
  logic        enc_start;
  logic        enc_done;
  logic [15:0] enc_result;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  msg_count;

  rsa_message_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .enc_data    (enc_data),
    .enc_start   (enc_start),
    .enc_done    (enc_done),
    .enc_result  (enc_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .msg_count   (msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus knobs, written only by the scenario process.
  bit          rst_req;
  int unsigned in_rate;
  int unsigned ordy_rate;
  int unsigned dmin;
  int unsigned dmax;
  bit          enc_stuck;
  logic [7:0]  src_buf [0:1023];
  int          src_wr;

  // Written only by the per-cycle process.
  int          src_rd;
  int          cyc;
  int          n_vec;
  int          n_starts;
  int          n_deliv;
  int          n_acc;
  logic [7:0]  last_start_byte;
  logic [15:0] last_out_word;

  int n_cmp;
  int n_bad;

  // Reference model: pending bytes, in-flight byte with its launch cycle,
  // pending output word, and the architectural counters.
  logic [7:0]  m_q [$];
  bit          m_live;
  bit          m_inflight;
  bit          m_emit;
  int          m_launch;
  logic [7:0]  m_cur;
  logic [15:0] m_word;
  bit          m_err;
  int          m_msg;

  // Encryptor model state.
  bit          e_act;
  int          e_t;
  int          e_delay;
  logic [7:0]  e_byte;

  function automatic logic [15:0] rsa_enc(input logic [7:0] m);
    int unsigned r;
    r = 1;
    for (int i = 0; i < 17; i++) r = (r * 32'(m)) % 3233;
    return 16'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit acc;
    int k;
    cyc++;
    if (m_live) begin
      n_vec++;
      chk("in_ready",    32'(in_ready),    32'(m_q.size() < FIFO_DEPTH));
      chk("busy",        32'(busy),        32'(m_inflight || m_emit));
      chk("enc_start",   32'(enc_start),   32'(m_inflight && (cyc == m_launch)));
      chk("enc_data",    32'(enc_data),    32'(m_cur));
      chk("out_valid",   32'(out_valid),   32'(m_emit));
      chk("out_data",    32'(out_data),    32'(m_word));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      chk("msg_count",   32'(msg_count),   32'(m_msg));
    end

    rst       = rst_req;
    in_valid  = (src_rd != src_wr) && ($urandom_range(99) < in_rate);
    in_data   = in_valid ? src_buf[src_rd % 1024] : 8'($urandom);
    out_ready = ($urandom_range(99) < ordy_rate);
    if (in_valid && in_ready && !rst) begin
      src_rd++;
      n_acc++;
    end

    // Encryptor: done keeps its old level for one cycle after the start pulse,
    // then drops until the result is ready.
    if (enc_start === 1'b1) begin
      e_byte  = enc_data;
      e_t     = 0;
      e_act   = 1'b1;
      e_delay = enc_stuck ? (1 << 30) : int'($urandom_range(dmax, dmin));
      n_starts++;
      last_start_byte = enc_data;
    end else if (e_act) begin
      e_t++;
      if (e_t >= 2 && e_t < 1 + e_delay) begin
        enc_done   = 1'b0;
        enc_result = 16'($urandom);
      end else if (e_t >= 1 + e_delay) begin
        enc_done   = 1'b1;
        enc_result = rsa_enc(e_byte);
        e_act      = 1'b0;
      end
    end

    if (!rst && out_valid === 1'b1 && out_ready) begin
      n_deliv++;
      last_out_word = out_data;
    end

    if (rst) begin
      m_q.delete();
      m_live     = 1'b1;
      m_inflight = 1'b0;
      m_emit     = 1'b0;
      m_launch   = -10;
      m_cur      = '0;
      m_word     = '0;
      m_err      = 1'b0;
      m_msg      = 0;
    end else if (m_live) begin
      acc = in_valid && (m_q.size() < FIFO_DEPTH);
      if (!m_inflight && !m_emit) begin
        if (m_q.size() > 0) begin
          m_cur      = m_q.pop_front();
          m_inflight = 1'b1;
          m_launch   = cyc + 1;
        end
      end else if (m_inflight) begin
        if (cyc > m_launch) begin
          k = cyc - m_launch - 1;
          if (k >= 1 && enc_done) begin
            m_word     = enc_result;
            m_emit     = 1'b1;
            m_inflight = 1'b0;
          end else if (k == TIMEOUT - 1) begin
            m_err      = 1'b1;
            m_inflight = 1'b0;
          end
        end
      end else if (out_ready) begin
        chk("e2e_word", 32'(out_data), 32'(rsa_enc(m_cur)));
        m_msg  = (m_msg + 1) % 256;
        m_emit = 1'b0;
      end
      if (acc) m_q.push_back(in_data);
    end
  end

  task automatic push(input logic [7:0] b);
    src_buf[src_wr % 1024] = b;
    src_wr++;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (src_rd == src_wr && m_q.size() == 0 && !m_inflight && !m_emit) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", tag, budget);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int s0, d0, a0, low_acc, base, need;
    bit hit;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    enc_done = 1'b0; enc_result = '0;
    rst_req = 1'b1; in_rate = 100; ordy_rate = 100; dmin = 1; dmax = 1; enc_stuck = 1'b0;

    chk("pin_rsa65", 32'(rsa_enc(8'd65)), 32'd2790);
    chk("pin_rsa2",  32'(rsa_enc(8'd2)),  32'd1752);

    repeat (3) @(posedge clk);
    rst_req = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_msg_count", 32'(msg_count), 32'd0);

    // Single byte, encryptor completes after 30 cycles.
    dmin = 30; dmax = 30; s0 = n_starts;
    push(8'd65);
    wait_idle(200, "single_byte");
    chk("single_starts",    32'(n_starts - s0),   32'd1);
    chk("single_enc_data",  32'(last_start_byte), 32'd65);
    chk("single_out_word",  32'(last_out_word),   32'd2790);
    chk("single_msg_count", 32'(msg_count),       32'd1);

    // Back-to-back burst while the encryptor is slow: FIFO fills behind one in flight.
    dmin = 60; dmax = 60; a0 = n_acc; d0 = n_deliv; low_acc = -1;
    for (int i = 1; i <= 5; i++) push(8'(10 * i));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (!in_ready) begin
        low_acc = n_acc - a0;
        break;
      end
    end
    chk("burst_acc_at_full", 32'(low_acc), 32'd5);
    wait_idle(600, "burst");
    chk("burst_delivered", 32'(n_deliv - d0), 32'd5);
    chk("burst_last_word", 32'(last_out_word), 32'(rsa_enc(8'd50)));

    // Downstream stall in EMIT with another byte waiting.
    dmin = 5; dmax = 5; ordy_rate = 0;
    push(8'd2); push(8'd3);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (m_emit) begin hit = 1'b1; break; end
    end
    chk("stall_reached_emit", 32'(hit), 32'd1);
    s0 = n_starts;
    repeat (20) @(negedge clk);
    #1;
    chk("stall_no_start",  32'(n_starts - s0), 32'd0);
    chk("stall_out_valid", 32'(out_valid),     32'd1);
    chk("stall_out_data",  32'(out_data),      32'd1752);
    ordy_rate = 100;
    wait_idle(200, "stall");

    // Encryptor never completes.
    enc_stuck = 1'b1;
    push(8'd7);
    wait_idle(TIMEOUT + 100, "timeout");
    chk("timeout_flag", 32'(timeout_err), 32'd1);
    chk("timeout_idle", 32'(busy),        32'd0);
    enc_stuck = 1'b0; dmin = 1; dmax = 4;
    push(8'd42);
    wait_idle(100, "after_timeout");
    chk("after_timeout_word",   32'(last_out_word), 32'(rsa_enc(8'd42)));
    chk("after_timeout_sticky", 32'(timeout_err),   32'd1);

    // Reset in the middle of WAIT.
    dmin = 40; dmax = 40;
    push(8'd99);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (m_inflight && cyc > m_launch + 3) begin hit = 1'b1; break; end
    end
    chk("midwait_reached", 32'(hit), 32'd1);
    rst_req = 1'b1;
    @(posedge clk);
    rst_req = 1'b0;
    @(negedge clk); #1;
    chk("midwait_msg_count", 32'(msg_count),   32'd0);
    chk("midwait_out_valid", 32'(out_valid),   32'd0);
    chk("midwait_busy",      32'(busy),        32'd0);
    chk("midwait_err",       32'(timeout_err), 32'd0);
    chk("midwait_enc_start", 32'(enc_start),   32'd0);
    chk("midwait_enc_data",  32'(enc_data),    32'd0);
    chk("midwait_in_ready",  32'(in_ready),    32'd1);
    base = n_deliv;

    // Randomized traffic.
    ordy_rate = 60; dmin = 1; dmax = 8;
    in_rate = $urandom_range(100, 30);
    for (int i = 0; i < 40; i++) push(8'($urandom));
    wait_idle(2000, "random");

    // Fill up to 256 deliveries since reset: counter must wrap.
    need = 256 - (n_deliv - base);
    in_rate = 100; ordy_rate = 100; dmin = 1; dmax = 2;
    for (int i = 0; i < need; i++) push(8'($urandom));
    wait_idle(4000, "wrap");
    chk("wrap_delivered", 32'(n_deliv - base), 32'd256);
    chk("wrap_msg_count", 32'(msg_count),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_message_sequencer.md
RSA_MESSAGE_SEQUENCER -- requirements
Module: rsa_message_sequencer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, 4, plaintext byte buffer entries (power of 2, >=2).
REQ-002 Parameters SHALL include: TIMEOUT, 1023, maximum cycles to wait for encryptor completion.
REQ-003 Port SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-004 Port SHALL be: rst  in  1  reset, synchronous and active-high.
REQ-005 Port SHALL be: in_data  in  8  plaintext byte from upstream.
REQ-006 Port SHALL be: in_valid  in  1  in_data valid.
REQ-007 Port SHALL be: in_ready  out  1  buffer not full; a byte transfers when in_valid&in_ready.
REQ-008 Port SHALL be: enc_data  out  8  byte presented to encryptor data input.
REQ-009 Port SHALL be: enc_start  out  1  one-cycle pulse to encryptor input_data_ready.
REQ-010 Port SHALL be: enc_done  in  1  encryptor done level.
REQ-011 Port SHALL be: enc_result  in  16  encryptor output_data.
REQ-012 Port SHALL be: out_data  out  16  ciphertext word.
REQ-013 Port SHALL be: out_valid  out  1  out_data valid.
REQ-014 Port SHALL be: out_ready  in  1  downstream accepts; transfer when out_valid&out_ready.
REQ-015 Port SHALL be: busy  out  1  high in any state other than IDLE.
REQ-016 Port SHALL be: timeout_err  out  1  sticky timeout flag.
REQ-017 Port SHALL be: msg_count  out  8  count of ciphertext words delivered, wraps 255->0.

Function
REQ-018 Byte FIFO SHALL hold FIFO_DEPTH entries; in_ready = not full; simultaneous push and pop when full SHALL be refused (in_ready low), when empty SHALL not bypass.
REQ-019 FSM states SHALL be IDLE, LAUNCH, WAIT, EMIT.
REQ-020 IDLE: if FIFO non-empty, pop head into enc_data register and go to LAUNCH next cycle.
REQ-021 LAUNCH: enc_start=1 for exactly this one cycle, enc_data held stable; go to WAIT.
REQ-022 enc_data SHALL remain stable from LAUNCH through end of WAIT.
REQ-023 WAIT: first cycle ignores enc_done (stale level); from second cycle, enc_done=1 captures enc_result into out_data and goes to EMIT.
REQ-024 WAIT cycle counter SHALL count from 0; reaching TIMEOUT without enc_done sets timeout_err, discards the byte, returns to IDLE.
REQ-025 EMIT: out_valid=1, out_data held until out_ready=1; on transfer msg_count increments, go to IDLE.
REQ-026 Latency from FIFO-non-empty in IDLE to enc_start SHALL be 2 cycles; from qualified enc_done to out_valid SHALL be 1 cycle.
REQ-027 Only one byte SHALL be in flight; FIFO SHALL keep accepting during WAIT/EMIT.
REQ-028 timeout_err SHALL clear only on reset.

Reset
REQ-029 rst SHALL, on the clock edge, set state IDLE, FIFO empty, pointers 0, enc_start=0, enc_data=0, out_valid=0, out_data=0, msg_count=0, timeout_err=0, wait counter 0; in_ready=1 from the first cycle after reset.
REQ-030 rst during WAIT or EMIT SHALL abandon the in-flight byte and any pending output with no enc_start issued.

Structure
REQ-031 A shared package SHALL hold the state encoding, data widths (8, 16), and default FIFO_DEPTH/TIMEOUT constants.
REQ-032 The byte FIFO SHALL be a sub-module named rsa_byte_fifo; FSM and output register stay in the top.

Verification
REQ-033 Push 65 with encryptor model done after 30 cycles returning 2790 -> one enc_start pulse with enc_data=65, out_data=2790, msg_count=1.
REQ-034 Push 5 bytes back-to-back with done held off -> in_ready low after 4 accepted bytes (plus in-flight one), all 5 outputs in order.
REQ-035 Hold out_ready=0 for 20 cycles in EMIT -> out_data/out_valid stable, no new enc_start.
REQ-036 enc_done stuck low -> timeout_err=1 after TIMEOUT cycles, state IDLE, next byte processed normally.
REQ-037 Assert rst mid-WAIT -> all outputs at reset values next cycle, FIFO empty.
REQ-038 Deliver 256 words -> msg_count wraps to 0.
